// File: rtl/axi_lite_wr_rd_master.sv
// Single-outstanding AXI-lite initiator: one command in, one AXI write or read, one response out.
// Optional response watchdog enabled by defining AXI_LITE_MST_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | cmd_ready high, waiting for a command
// WR_REQ    | AW and W presented, each drops after its own handshake
// WR_RESP   | bready high, waiting for B
// RD_REQ    | arvalid high, waiting for AR handshake
// RD_DATA   | rready high, waiting for R
// RSP       | response held until rsp_ready
module axi_lite_wr_rd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [ADDR_W-1:0]   axi_awaddr,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  output logic [DATA_W-1:0]   axi_wdata,
  output logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_bvalid,
  output logic                axi_bready,
  input  logic [1:0]          axi_bresp,
  output logic                axi_arvalid,
  input  logic                axi_arready,
  output logic [ADDR_W-1:0]   axi_araddr,
  input  logic                axi_rvalid,
  output logic                axi_rready,
  input  logic [DATA_W-1:0]   axi_rdata,
  input  logic [1:0]          axi_rresp
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;

`ifdef AXI_LITE_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
`ifdef AXI_LITE_MST_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
`ifdef AXI_LITE_MST_TIMEOUT_EN
          cnt_d       = '0;
`endif
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            araddr_d  = cmd_addr;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // a cleared valid flop doubles as the per-channel done flag
        awvalid_d = awvalid_q & ~axi_awready;
        wvalid_d  = wvalid_q & ~axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (axi_bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_resp_d  = axi_bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (arvalid_q && axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (axi_rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_resp_d  = axi_rresp;
          rsp_rdata_d = axi_rdata;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AXI_LITE_MST_TIMEOUT_EN
    if (state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA}) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_resp_d  = 2'b10;
        rsp_rdata_d = '0;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
`ifdef AXI_LITE_MST_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
`ifdef AXI_LITE_MST_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_bready  = bready_q;
  assign axi_arvalid = arvalid_q;
  assign axi_araddr  = araddr_q;
  assign axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_wr_rd_master.sv
// Bench for axi_lite_wr_rd_master: directed and randomized commands against a reactive AXI slave.
// Expected latency/response come from a cycle-count model of the command-to-response path.
module tb_axi_lite_wr_rd_master;

`ifdef AXI_LITE_MST_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [1:0]  axi_bresp, axi_rresp;

  always #5 clk = ~clk;

  axi_lite_wr_rd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // slave knobs, written by the stimulus process only
  int          k_aw_d = 0, k_w_d = 0, k_b_d = 0, k_ar_d = 0, k_r_d = 0;
  logic [1:0]  k_bresp = '0, k_rresp = '0;
  logic [31:0] k_rdata = '0;
  bit          k_ar_never = 1'b0;
  int          epoch = 0;

  // slave observations, written by the slave process only
  int          s_aw_seen, s_w_seen, s_ar_seen;
  int          s_proto = 0;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;

  initial begin : slave
    int my_epoch;
    bit aw_got, w_got, ar_got, b_done, r_done;
    int bcnt, rcnt;
    my_epoch = -1;
    aw_got = 0; w_got = 0; ar_got = 0; b_done = 0; r_done = 0; bcnt = 0; rcnt = 0;
    s_aw_seen = 0; s_w_seen = 0; s_ar_seen = 0;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0; s_wstrb = '0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = '0;
    axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = '0;
    forever begin
      @(negedge clk);
      if (epoch != my_epoch) begin
        my_epoch = epoch;
        aw_got = 0; w_got = 0; ar_got = 0; b_done = 0; r_done = 0; bcnt = 0; rcnt = 0;
        s_aw_seen = 0; s_w_seen = 0; s_ar_seen = 0;
        axi_bvalid = 0; axi_bresp = '0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = '0;
      end
      // B and R use handshake flags decided at earlier negedges
      if (axi_bready && !(aw_got && w_got)) s_proto++;
      if (aw_got && w_got && !b_done) begin
        if (bcnt >= k_b_d) begin
          axi_bvalid = 1; axi_bresp = k_bresp;
          if (axi_bready) b_done = 1;
        end else bcnt++;
      end else begin
        axi_bvalid = 0; axi_bresp = '0;
      end
      if (axi_rready && !ar_got) s_proto++;
      if (ar_got && !r_done) begin
        if (rcnt >= k_r_d) begin
          axi_rvalid = 1; axi_rdata = k_rdata; axi_rresp = k_rresp;
          if (axi_rready) r_done = 1;
        end else rcnt++;
      end else begin
        axi_rvalid = 0; axi_rdata = '0; axi_rresp = '0;
      end
      axi_awready = 0;
      if (axi_awvalid) begin
        if (aw_got) s_proto++;
        else begin
          if (s_aw_seen == 0) s_awaddr = axi_awaddr;
          else if (axi_awaddr !== s_awaddr) s_proto++;
          s_aw_seen++;
          if (s_aw_seen > k_aw_d) begin axi_awready = 1; aw_got = 1; end
        end
      end else if (s_aw_seen > 0 && !aw_got) s_proto++;
      axi_wready = 0;
      if (axi_wvalid) begin
        if (w_got) s_proto++;
        else begin
          if (s_w_seen == 0) begin s_wdata = axi_wdata; s_wstrb = axi_wstrb; end
          else if (axi_wdata !== s_wdata || axi_wstrb !== s_wstrb) s_proto++;
          s_w_seen++;
          if (s_w_seen > k_w_d) begin axi_wready = 1; w_got = 1; end
        end
      end else if (s_w_seen > 0 && !w_got) s_proto++;
      axi_arready = 0;
      if (axi_arvalid) begin
        if (ar_got) s_proto++;
        else begin
          if (s_ar_seen == 0) s_araddr = axi_araddr;
          else if (axi_araddr !== s_araddr) s_proto++;
          s_ar_seen++;
          if (!k_ar_never && s_ar_seen > k_ar_d) begin axi_arready = 1; ar_got = 1; end
        end
      end else if (s_ar_seen > 0 && !ar_got && !k_ar_never) s_proto++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  // entered at the negedge of cycle 1 (cycle 0 holds the command handshake)
  task automatic wait_rsp(input int exp_lat, input logic [31:0] exp_rd, input logic [1:0] exp_rs,
                          input int hold);
    int k;
    k = 1;
    while (rsp_valid !== 1'b1 && k < 100) begin
      chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      k++;
    end
    chk("rsp_latency", 64'(k), 64'(exp_lat));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
    chk("rsp_resp", 64'(rsp_resp), 64'(exp_rs));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_hold_resp", 64'(rsp_resp), 64'(exp_rs));
      chk("rsp_hold_rdata", 64'(rsp_rdata), 64'(exp_rd));
      chk("rsp_hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_consumed", 64'(rsp_valid), 64'd0);
    chk("cmd_ready_after", 64'(cmd_ready), 64'd1);
  endtask

  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int daw, input int dw, input int db,
                        input int dar, input int dr, input logic [1:0] resp,
                        input logic [31:0] rdata, input int hold);
    int exp_lat;
    logic [31:0] exp_rd;
    k_aw_d = daw; k_w_d = dw; k_b_d = db; k_ar_d = dar; k_r_d = dr;
    k_bresp = resp; k_rresp = resp; k_rdata = rdata; k_ar_never = 0;
    epoch++;
    if (wr) begin
      exp_lat = 3 + ((daw > dw) ? daw : dw) + db;
      exp_rd  = '0;
    end else begin
      exp_lat = 3 + dar + dr;
      exp_rd  = rdata;
    end
    issue(wr, addr, data, strb);
    wait_rsp(exp_lat, exp_rd, resp, hold);
    if (wr) begin
      chk("bus_awaddr", 64'(s_awaddr), 64'(addr));
      chk("bus_wdata", 64'(s_wdata), 64'(data));
      chk("bus_wstrb", 64'(s_wstrb), 64'(strb));
      chk("awvalid_cycles", 64'(s_aw_seen), 64'(daw + 1));
      chk("wvalid_cycles", 64'(s_w_seen), 64'(dw + 1));
      chk("no_ar_on_write", 64'(s_ar_seen), 64'd0);
    end else begin
      chk("bus_araddr", 64'(s_araddr), 64'(addr));
      chk("arvalid_cycles", 64'(s_ar_seen), 64'(dar + 1));
      chk("no_aw_on_read", 64'(s_aw_seen + s_w_seen), 64'd0);
    end
    chk("protocol_errors", 64'(s_proto), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_valids", 64'({axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, rsp_valid}), 64'd0);
    chk("rst_payload", 64'({axi_awaddr, axi_wdata} | 64'({axi_araddr, rsp_rdata}) | 64'({axi_wstrb, rsp_resp})), 64'd0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    do_txn(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    do_txn(1, 32'h0000_0014, 32'hCAFE_F00D, 4'h3, 3, 0, 0, 0, 0, 2'b00, 32'h0, 1);
    do_txn(0, 32'h0000_0020, 32'h0, 4'h0, 0, 0, 0, 0, 2, 2'b00, 32'h1234_5678, 0);
    do_txn(1, 32'h0000_0030, 32'h0BAD_0BAD, 4'hA, 0, 2, 1, 0, 0, 2'b10, 32'h0, 5);
    do_txn(0, 32'h0000_0040, 32'h0, 4'h0, 2, 0, 0, 1, 0, 2'b11, 32'hA5A5_5A5A, 2);

    // reset while waiting for B
    k_aw_d = 0; k_w_d = 0; k_b_d = 5; k_bresp = 2'b00; k_ar_never = 0;
    epoch++;
    issue(1, 32'h0000_0050, 32'h5555_AAAA, 4'hF);
    n = 0;
    while (axi_bready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("reached_wr_resp", 64'(axi_bready), 64'd1);
    rst = 1;
    epoch++;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_axi_valids", 64'({axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}), 64'd0);
    chk("mid_rst_addr", 64'({axi_awaddr, axi_araddr}), 64'd0);
    chk("mid_rst_wdata", 64'({axi_wdata, 28'd0, axi_wstrb}), 64'd0);
    chk("mid_rst_rsp", 64'({rsp_valid, rsp_resp, rsp_rdata}), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
      chk("post_rst_ready", 64'(cmd_ready), 64'd1);
    end
    do_txn(0, 32'h0000_0060, 32'h0, 4'h0, 0, 0, 0, 0, 1, 2'b00, 32'h0F0F_1234, 0);

`ifdef AXI_LITE_MST_TIMEOUT_EN
    k_ar_never = 1; k_aw_d = 0; k_w_d = 0; k_b_d = 0; k_r_d = 0;
    epoch++;
    issue(0, 32'h0000_0070, 32'h0, 4'h0);
    wait_rsp(TO + 1, 32'h0, 2'b10, 1);
    chk("timeout_arvalid_cycles", 64'(s_ar_seen), 64'(TO));
    chk("timeout_arvalid_low", 64'(axi_arvalid), 64'd0);
    k_ar_never = 0;
`endif

    for (int t = 0; t < 24; t++) begin
      bit          wr;
      logic [31:0] addr, data, rdata;
      logic [3:0]  strb;
      logic [1:0]  resp;
      wr    = 1'($urandom_range(0, 1));
      addr  = $urandom & 32'hFFFF_FFFC;
      data  = $urandom;
      rdata = $urandom;
      strb  = 4'($urandom_range(0, 15));
      resp  = 2'($urandom_range(0, 3));
      do_txn(wr, addr, data, strb,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
             resp, rdata, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_wr_rd_master.md
Name: axi_lite_wr_rd_master

Overview:
- Single-outstanding AXI-lite initiator. Converts a simple command/response handshake into AXI write (AW/W/B) or read (AR/R) transactions.
- Drives the AXI slave ports of the interconnect, both in the testbench harness and from on-chip agents such as the config sequencer.
- Issues one transaction at a time. AW and W are presented concurrently. The response is held until the requester consumes it.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width; strobe width is DATA_W/8
TIMEOUT_CYCLES, 256, response watchdog limit (used only with optional feature)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_resp  out  2  AXI BRESP/RRESP captured
axi_awvalid  out  1  write address valid
axi_awready  in  1  write address ready
axi_awaddr  out  ADDR_W  write address
axi_wvalid  out  1  write data valid
axi_wready  in  1  write data ready
axi_wdata  out  DATA_W  write data
axi_wstrb  out  DATA_W/8  write strobes
axi_bvalid  in  1  write response valid
axi_bready  out  1  write response ready
axi_bresp  in  2  write response code
axi_arvalid  out  1  read address valid
axi_arready  in  1  read address ready
axi_araddr  out  ADDR_W  read address
axi_rvalid  in  1  read data valid
axi_rready  out  1  read data ready
axi_rdata  in  DATA_W  read data
axi_rresp  in  2  read response code

Behaviour:
- Reset (rst=1 at clk edge): FSM to IDLE. All valid/ready outputs 0. cmd_ready 0 during the reset cycle. rsp_rdata, rsp_resp, addr/data/strb outputs 0. Any in-flight transaction is abandoned and no response is generated. Reset takes priority over every other event.
- All outputs are registered.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: cmd_ready=1. On handshake, latch addr/wdata/wstrb.
  - Write: next cycle axi_awvalid=axi_wvalid=1, go WR_REQ.
  - Read: next cycle axi_arvalid=1, go RD_REQ.
  - cmd_ready=0 in all states other than IDLE.
- WR_REQ: track aw_done and w_done independently.
  - Deassert axi_awvalid the cycle after awvalid&awready. Same for W.
  - Valid is never dropped before its handshake.
  - Payload is stable while valid.
  - When both are done (same or different cycles), go WR_RESP with axi_bready=1.
- WR_RESP: on bvalid&bready, capture bresp into rsp_resp, set rsp_rdata=0, bready=0, rsp_valid=1, go RSP.
- RD_REQ: on arvalid&arready, arvalid=0, rready=1, go RD_DATA.
- RD_DATA: on rvalid&rready, capture rdata/rresp, rready=0, rsp_valid=1, go RSP.
- RSP: hold rsp_* stable until rsp_ready.
  - On rsp_ready: rsp_valid=0 and go IDLE. cmd_ready=1 the following cycle; no back-to-back bypass.
- Minimum latency with zero-wait slave:
  - Write: cmd handshake cycle 0, AW/W cycle 1, B cycle 2, rsp_valid cycle 3.
  - Read: AR cycle 1, R cycle 2, rsp_valid cycle 3.
- B or R arriving before its ready is asserted is ignored; the slave must hold it.
- Non-OKAY responses are passed through unmodified.

Optional Feature:
AXI_LITE_MST_TIMEOUT_EN
- Defined: a counter clears on entry to WR_REQ or RD_REQ and increments every cycle in WR_REQ/WR_RESP/RD_REQ/RD_DATA.
  - On reaching TIMEOUT_CYCLES: drop all AXI valid/ready outputs, set rsp_resp=2'b10 (SLVERR), rsp_rdata=0, rsp_valid=1, go RSP.
  - A later stray B/R is ignored because ready is 0.
- Undefined: no counter. The FSM waits indefinitely.

Test Plan:
- Write 0x0000_0010 data 0xDEAD_BEEF strb 0xF; slave awready=wready=1, bresp=0 next cycle -> AW/W on cycle 1, rsp_valid on cycle 3, rsp_resp=0, rsp_rdata=0.
- Write with awready delayed 3 cycles, wready immediate -> wvalid drops after cycle 1, awvalid held until cycle 4, bready rises only after both done, single response.
- Read 0x0000_0020; slave returns rdata 0x1234_5678 rresp=0 with 2-cycle gap -> rsp_rdata=0x1234_5678, rsp_resp=0; arvalid high only until accepted.
- Write with bresp=2'b10, rsp_ready held low 5 cycles -> rsp_valid/rsp_resp=2'b10 stable 5 cycles, cmd_ready=0 throughout, cmd_ready=1 the cycle after consume.
- Assert rst for 1 cycle while in WR_RESP -> all AXI outputs 0, rsp_valid never asserted, cmd_ready=1 the cycle after rst deasserts, next read completes normally.
- With AXI_LITE_MST_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never asserts arready -> arvalid drops after 8 cycles, rsp_valid=1, rsp_resp=2'b10.
